// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial-pattern detection controller:
// FSM state encoding and default parameter values.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_FRM_W = 8;

endpackage

// File: rtl/seq_det_window.sv
// Sliding bit window for the pattern detector: shift history, saturating
// fill counter and the length-masked compare against the latched pattern.
// The hit output is combinational so the match lands on the completing bit.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic             in_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             clear_fill_i,
  output logic             hit_o
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [PAT_W:0]    win;
  logic [PAT_W:0]    mask;
  logic              fill_ok;

  // Masked compare of the newest len bits (history plus the arriving bit).
  // Requiring fill+1 >= len guarantees every compared bit belongs to the
  // current job and, in non-overlap mode, follows the previous match.
  always_comb begin
    win     = {hist_q, in_i};
    mask    = ({{PAT_W{1'b0}}, 1'b1} << len_i) - {{PAT_W{1'b0}}, 1'b1};
    fill_ok = (int'(fill_q) + 1) >= int'(len_i);
    hit_o   = in_valid_i && fill_ok &&
              ((win & mask) == ({1'b0, pattern_i} & mask));
  end

  // History shifts on every accepted bit; fill saturates at PAT_W and is
  // dropped to zero after a non-overlapping match.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (in_valid_i) begin
      hist_q <= {hist_q[PAT_W-2:0], in_i};
      if (clear_fill_i)
        fill_q <= '0;
      else if (fill_q != FILL_W'(PAT_W))
        fill_q <= fill_q + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller. One job per Start:
// latch the configuration, examine Cfg_Frame valid bits, pulse Match on
// each hit, keep a saturating match count and close with a Done pulse.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int FRM_W = DEF_FRM_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [PAT_W-1:0] Cfg_Pattern,
  input  logic [LEN_W-1:0] Cfg_Len,
  input  logic             Cfg_Overlap,
  input  logic [FRM_W-1:0] Cfg_Frame,
  input  logic             In_Valid,
  input  logic             In,
  output logic             Busy,
  output logic             Match,
  output logic [CNT_W-1:0] Match_Cnt,
  output logic             Done,
  output logic             Err
);

  localparam logic [LEN_W:0] PAT_W_L = (LEN_W + 1)'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic [FRM_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             err_q, err_d;

  logic             cfg_bad;
  logic             win_clear;
  logic             win_valid;
  logic             hit;
  logic             clear_fill;

  assign cfg_bad    = (Cfg_Len == '0) || ({1'b0, Cfg_Len} > PAT_W_L) ||
                      (Cfg_Frame == '0);
  assign win_valid  = (state_q == ST_RUN) && In_Valid;
  assign clear_fill = hit && !overlap_q;

  seq_det_window #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .Clk          (Clk),
    .Rst          (Rst),
    .clear_i      (win_clear),
    .in_valid_i   (win_valid),
    .in_i         (In),
    .len_i        (len_q),
    .pattern_i    (pattern_q),
    .clear_fill_i (clear_fill),
    .hit_o        (hit)
  );

  // Next-state logic: job acceptance, bit/match counting and frame end.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    err_d       = err_q;
    win_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          pattern_d   = Cfg_Pattern;
          len_d       = Cfg_Len;
          overlap_d   = Cfg_Overlap;
          frame_d     = Cfg_Frame;
          bit_cnt_d   = '0;
          match_cnt_d = '0;
          win_clear   = 1'b1;
          err_d       = cfg_bad;
          state_d     = cfg_bad ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (In_Valid) begin
          bit_cnt_d = bit_cnt_q + FRM_W'(1);
          if (hit && (match_cnt_q != '1))
            match_cnt_d = match_cnt_q + CNT_W'(1);
          if (bit_cnt_q == (frame_q - FRM_W'(1)))
            state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and counters, cleared asynchronously by Rst.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
    end
  end

  // Latched job configuration; only meaningful after an accepted Start.
  always_ff @(posedge Clk) begin
    pattern_q <= pattern_d;
    len_q     <= len_d;
    overlap_q <= overlap_d;
    frame_q   <= frame_d;
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Match     = hit;
  assign Match_Cnt = match_cnt_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus randomized jobs checked
// against an array-based reference model of the detection rules. A second
// instance with a 2-bit match counter shares all inputs.
module tb_seq_det_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic [7:0] Cfg_Pattern;
  logic [3:0] Cfg_Len;
  logic       Cfg_Overlap;
  logic [7:0] Cfg_Frame;
  logic       In_Valid;
  logic       In;

  logic       Busy, Match, Done, Err;
  logic [7:0] Match_Cnt;
  logic       Busy2, Match2, Done2, Err2;
  logic [1:0] Match_Cnt2;

  int checks   = 0;
  int failures = 0;

  bit stim_bits [0:255];
  bit exp_hit   [0:255];
  int prev_cnt  = 0;
  int prev_cnt2 = 0;
  bit prev_err  = 0;

  seq_det_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Cfg_Pattern(Cfg_Pattern),
    .Cfg_Len(Cfg_Len), .Cfg_Overlap(Cfg_Overlap), .Cfg_Frame(Cfg_Frame),
    .In_Valid(In_Valid), .In(In), .Busy(Busy), .Match(Match),
    .Match_Cnt(Match_Cnt), .Done(Done), .Err(Err)
  );

  seq_det_ctrl #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Cfg_Pattern(Cfg_Pattern),
    .Cfg_Len(Cfg_Len), .Cfg_Overlap(Cfg_Overlap), .Cfg_Frame(Cfg_Frame),
    .In_Valid(In_Valid), .In(In), .Busy(Busy2), .Match(Match2),
    .Match_Cnt(Match_Cnt2), .Done(Done2), .Err(Err2)
  );

  always #5 Clk = ~Clk;

  // Reference: walk the valid-bit list; a hit needs len bits since the
  // last restart point whose newest bit equals pat[0], oldest pat[len-1].
  function automatic int model(input logic [7:0] pat, input int len,
                               input bit ovl, input int frame);
    int start = 0;
    int n = 0;
    for (int i = 0; i < frame; i++) begin
      bit ok;
      exp_hit[i] = 1'b0;
      if (i - start + 1 >= len) begin
        ok = 1'b1;
        for (int k = 0; k < len; k++)
          if (stim_bits[i-k] != pat[k]) ok = 1'b0;
        if (ok) begin
          exp_hit[i] = 1'b1;
          n++;
          if (!ovl) start = i + 1;
        end
      end
    end
    return n;
  endfunction

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic scramble_cfg();
    Cfg_Pattern = 8'($urandom);
    Cfg_Len     = 4'($urandom);
    Cfg_Overlap = 1'($urandom);
    Cfg_Frame   = 8'($urandom);
  endtask

  // Runs one job starting on the next negedge and checks every cycle.
  task automatic run_job(input logic [7:0] pat, input logic [3:0] len,
                         input bit ovl, input logic [7:0] frame,
                         input int gmin, input int gmax,
                         output int oc, output int oc2, output bit oerr);
    bit bad;
    int n;
    int e1, e2;
    bad = (len == 0) || (len > 8) || (frame == 0);
    n   = bad ? 0 : model(pat, int'(len), ovl, int'(frame));
    e1  = sat(n, 255);
    e2  = sat(n, 3);
    @(negedge Clk);
    Start = 1'b1; Cfg_Pattern = pat; Cfg_Len = len; Cfg_Overlap = ovl;
    Cfg_Frame = frame; In_Valid = 1'($urandom); In = 1'($urandom);
    #1;
    checks++;
    if (Busy !== 1'b0 || Match !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL start_idle: busy=%b match=%b done=%b want 0 0 0", Busy, Match, Done);
    end
    checks++;
    if (int'(Match_Cnt) !== prev_cnt || int'(Match_Cnt2) !== prev_cnt2 || Err !== prev_err) begin
      failures++;
      $display("FAIL hold_before_start: cnt=%0d cnt2=%0d err=%b want %0d %0d %b",
               Match_Cnt, Match_Cnt2, Err, prev_cnt, prev_cnt2, prev_err);
    end
    @(posedge Clk);
    if (!bad) begin
      for (int i = 0; i < int'(frame); i++) begin
        int gaps;
        gaps = (i == 0 && gmin > 0) ? 0 : $urandom_range(gmax, gmin);
        for (int g = 0; g < gaps; g++) begin
          @(negedge Clk);
          In_Valid = 1'b0; In = 1'($urandom); Start = 1'($urandom); scramble_cfg();
          #1;
          checks++;
          if (Match !== 1'b0 || Match2 !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) begin
            failures++;
            $display("FAIL gap_cycle bit%0d: match=%b busy=%b done=%b want 0 1 0", i, Match, Busy, Done);
          end
          @(posedge Clk);
        end
        @(negedge Clk);
        In_Valid = 1'b1; In = stim_bits[i]; Start = 1'($urandom); scramble_cfg();
        #1;
        checks++;
        if (Match !== exp_hit[i] || Match2 !== exp_hit[i] || Busy !== 1'b1 || Done !== 1'b0) begin
          failures++;
          $display("FAIL match bit%0d: match=%b match2=%b busy=%b done=%b want %b %b 1 0",
                   i, Match, Match2, Busy, Done, exp_hit[i], exp_hit[i]);
        end
        @(posedge Clk);
      end
    end
    @(negedge Clk);
    Start = 1'b1; scramble_cfg(); In_Valid = 1'b1; In = 1'($urandom);
    #1;
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b1 || Match !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle: done=%b busy=%b match=%b want 1 1 0", Done, Busy, Match);
    end
    checks++;
    if (Err !== bad || int'(Match_Cnt) !== e1 || int'(Match_Cnt2) !== e2) begin
      failures++;
      $display("FAIL done_result: err=%b cnt=%0d cnt2=%0d want %b %0d %0d",
               Err, Match_Cnt, Match_Cnt2, bad, e1, e2);
    end
    oc = int'(Match_Cnt); oc2 = int'(Match_Cnt2); oerr = Err;
    prev_cnt = e1; prev_cnt2 = e2; prev_err = bad;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0; Start = 1'b0; In_Valid = 1'b1; In = 1'b1;
    Cfg_Pattern = 8'h01; Cfg_Len = 4'd1; Cfg_Overlap = 1'b1; Cfg_Frame = 8'd4;
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Match !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || Match_Cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b match=%b done=%b err=%b cnt=%0d want 0 0 0 0 0",
               Busy, Match, Done, Err, Match_Cnt);
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Match !== 1'b0 || Match_Cnt !== 8'd0) begin
      failures++;
      $display("FAIL idle_ignores_valid: busy=%b match=%b cnt=%0d want 0 0 0", Busy, Match, Match_Cnt);
    end
    In_Valid = 1'b0;
  endtask

  task automatic test_nonoverlap();
    int oc, oc2; bit oe;
    for (int i = 0; i < 10; i++) stim_bits[i] = (i % 2 == 0);
    run_job(8'b1010, 4'd4, 1'b0, 8'd10, 0, 0, oc, oc2, oe);
    checks++;
    if (oc !== 2 || oe !== 1'b0) begin
      failures++;
      $display("FAIL nonoverlap_count: cnt=%0d err=%b want 2 0", oc, oe);
    end
  endtask

  task automatic test_overlap();
    int oc, oc2; bit oe;
    for (int i = 0; i < 10; i++) stim_bits[i] = (i % 2 == 0);
    run_job(8'b1010, 4'd4, 1'b1, 8'd10, 0, 0, oc, oc2, oe);
    checks++;
    if (oc !== 4 || oc2 !== 3) begin
      failures++;
      $display("FAIL overlap_count: cnt=%0d cnt2=%0d want 4 3", oc, oc2);
    end
  endtask

  task automatic test_bad_cfg();
    int oc, oc2; bit oe;
    logic [3:0] lens [3] = '{4'd0, 4'd9, 4'd4};
    logic [7:0] frms [3] = '{8'd5, 8'd5, 8'd0};
    for (int j = 0; j < 3; j++) begin
      run_job(8'h0A, lens[j], 1'b0, frms[j], 0, 0, oc, oc2, oe);
      checks++;
      if (oe !== 1'b1 || oc !== 0) begin
        failures++;
        $display("FAIL bad_cfg%0d: err=%b cnt=%0d want 1 0", j, oe, oc);
      end
    end
  endtask

  task automatic test_gaps();
    int oc, oc2; bit oe;
    stim_bits[0] = 1; stim_bits[1] = 0; stim_bits[2] = 1; stim_bits[3] = 0;
    run_job(8'b1010, 4'd4, 1'b1, 8'd4, 3, 3, oc, oc2, oe);
    checks++;
    if (oc !== 1) begin
      failures++;
      $display("FAIL gaps_count: cnt=%0d want 1", oc);
    end
  endtask

  task automatic test_saturate();
    int oc, oc2; bit oe;
    for (int i = 0; i < 6; i++) stim_bits[i] = 1;
    run_job(8'b1, 4'd1, 1'b0, 8'd6, 0, 0, oc, oc2, oe);
    checks++;
    if (oc2 !== 3 || oc !== 6) begin
      failures++;
      $display("FAIL saturate: cnt2=%0d cnt=%0d want 3 6", oc2, oc);
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      Start = 1'b0; In_Valid = 1'b1; In = 1'($urandom); scramble_cfg();
      #1;
      checks++;
      if (Busy !== 1'b0 || Match !== 1'b0 || Done !== 1'b0 ||
          int'(Match_Cnt) !== prev_cnt || Err !== prev_err) begin
        failures++;
        $display("FAIL idle_hold c%0d: busy=%b match=%b done=%b cnt=%0d err=%b want 0 0 0 %0d %b",
                 c, Busy, Match, Done, Match_Cnt, Err, prev_cnt, prev_err);
      end
    end
  endtask

  task automatic test_abort();
    int n, oc, oc2; bit oe;
    for (int i = 0; i < 10; i++) stim_bits[i] = (i % 2 == 0);
    n = model(8'b1010, 4, 1'b1, 10);
    @(negedge Clk);
    Start = 1'b1; Cfg_Pattern = 8'b1010; Cfg_Len = 4'd4; Cfg_Overlap = 1'b1;
    Cfg_Frame = 8'd10; In_Valid = 1'b0;
    @(posedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      Start = 1'b0; In_Valid = 1'b1; In = stim_bits[i];
      #1;
      checks++;
      if (Match !== exp_hit[i] || Busy !== 1'b1) begin
        failures++;
        $display("FAIL abort_pre bit%0d: match=%b busy=%b want %b 1", i, Match, Busy, exp_hit[i]);
      end
      @(posedge Clk);
    end
    @(negedge Clk);
    Rst = 1'b0; In_Valid = 1'b1; In = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Match_Cnt !== 8'd0 || Done !== 1'b0 || Match !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: busy=%b cnt=%0d done=%b match=%b want 0 0 0 0",
               Busy, Match_Cnt, Done, Match);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if (c == 1) Rst = 1'b1;
      #1;
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done c%0d: done=%b busy=%b want 0 0", c, Done, Busy);
      end
    end
    In_Valid = 1'b0;
    prev_cnt = 0; prev_cnt2 = 0; prev_err = 1'b0;
    run_job(8'b1010, 4'd4, 1'b1, 8'd10, 0, 1, oc, oc2, oe);
    checks++;
    if (oc !== n) begin
      failures++;
      $display("FAIL abort_rerun: cnt=%0d want %0d", oc, n);
    end
  endtask

  task automatic test_random();
    int oc, oc2; bit oe;
    for (int j = 0; j < 60; j++) begin
      logic [7:0] pat;
      logic [3:0] len;
      logic [7:0] frame;
      bit ovl;
      pat   = 8'($urandom);
      len   = 4'($urandom_range(8, 1));
      frame = 8'($urandom_range(40, 1));
      ovl   = 1'($urandom);
      if ($urandom_range(9, 0) == 0) len = 4'($urandom_range(15, 9));
      if ($urandom_range(19, 0) == 0) frame = 8'd0;
      for (int i = 0; i < int'(frame); i++) begin
        if (j % 2 == 0 && len >= 1 && len <= 8) begin
          stim_bits[i] = pat[int'(len) - 1 - (i % int'(len))];
          if ($urandom_range(7, 0) == 0) stim_bits[i] = !stim_bits[i];
        end else begin
          stim_bits[i] = 1'($urandom);
        end
      end
      run_job(pat, len, ovl, frame, 0, 2, oc, oc2, oe);
    end
  endtask

  initial begin
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_hold();
    test_bad_cfg();
    test_gaps();
    test_saturate();
    test_abort();
    test_random();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
